// File: rtl/pim_arb_pkg.sv
// ----------------------------------------------------------------------------
// pim_arb_pkg
// Shared types and constants for the PIM_TOP access arbiter.
//   state_t  : access sequencer states (IDLE -> ISSUE -> [WAIT] -> RESP)
//   REQ_CORE : requester index of the RV core load/store path
//   REQ_SPI  : requester index of the SPI debug host
//   N_REQ    : number of requesters
//   CNT_W    : width of the read-latency down-counter
// ----------------------------------------------------------------------------
package pim_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int REQ_CORE = 0;
  localparam int REQ_SPI  = 1;
  localparam int N_REQ    = 2;
  localparam int CNT_W    = 3;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker.
//   clk    in   clock
//   srst   in   synchronous active-high reset (pointer favours REQ_CORE)
//   req    in   per-requester request, already masked by the caller
//   upd_en in   allow the pointer to advance when a grant is issued
//   gnt    out  one-hot grant (combinational from req and pointer)
//   ptr    out  registered pointer: the requester favoured on contention
// A lone requester always wins; on contention the pointer decides, and the
// pointer then moves to the side that lost.
// ----------------------------------------------------------------------------
module rr_arb2
  import pim_arb_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic [N_REQ-1:0] req,
  input  logic             upd_en,
  output logic [N_REQ-1:0] gnt,
  output logic             ptr
);

  logic ptr_reg;

  always_comb begin
    gnt = '0;
    if (req[REQ_CORE] && (!req[REQ_SPI] || (ptr_reg == 1'b0))) begin
      gnt[REQ_CORE] = 1'b1;
    end else if (req[REQ_SPI]) begin
      gnt[REQ_SPI] = 1'b1;
    end
  end

  // After granting the core, favour SPI next time, and vice versa.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= 1'b0;
    end else if (upd_en && (|gnt)) begin
      ptr_reg <= gnt[REQ_CORE];
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/pim_arbiter.sv
// ----------------------------------------------------------------------------
// pim_arbiter
// Shares the single PIM_TOP access port between the RV core load/store path
// (requester 0) and the SPI debug host (requester 1). One access at a time:
// grant in IDLE, one ISSUE cycle on the PIM port, RD_LAT cycles of WAIT for
// reads, then a one-cycle RESP pulse to the owner.
//   i_clk / i_rst        clock, synchronous active-high reset
//   i_req/i_we           per-requester request level and write flag
//   i_addr/i_wdata       per-requester address and write data
//   o_gnt                one-cycle grant pulse (request captured this cycle)
//   o_rvalid             one-cycle completion pulse to the owner
//   o_rdata              read data (0 for a write), valid with o_rvalid
//   o_pim_req            PIM strobe, ISSUE cycle only
//   o_pim_we/addr/wr_data PIM command fields, held between accesses
//   i_pim_rd_data        PIM read data, valid RD_LAT cycles after issue
//   o_busy               access in flight
// ----------------------------------------------------------------------------
module pim_arbiter
  import pim_arb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RD_LAT = 1    // 1..7
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0]           i_we,
  input  logic [N_REQ-1:0][XLEN-1:0] i_addr,
  input  logic [N_REQ-1:0][XLEN-1:0] i_wdata,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [N_REQ-1:0]           o_rvalid,
  output logic [XLEN-1:0]            o_rdata,
  output logic                       o_pim_req,
  output logic                       o_pim_we,
  output logic [XLEN-1:0]            o_pim_addr,
  output logic [XLEN-1:0]            o_pim_wr_data,
  input  logic [XLEN-1:0]            i_pim_rd_data,
  output logic                       o_busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [XLEN-1:0]   rdata_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              idle;
  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  arb_gnt;
  logic              rr_ptr;
  logic              owner;
  logic              sel;

  assign idle = (state_reg == IDLE);

  // Grants only happen in IDLE and never while reset is asserted.
  assign arb_req = (idle && !i_rst) ? i_req : '0;

  rr_arb2 u_rr_arb2 (
    .clk    (i_clk),
    .srst   (i_rst),
    .req    (arb_req),
    .upd_en (idle),
    .gnt    (arb_gnt),
    .ptr    (rr_ptr)
  );

  // The pointer advances on every grant to the side that was not granted,
  // and cannot move again until the next IDLE, so the current owner is
  // always the opposite of the pointer. No separate owner flop is needed.
  assign owner = ~rr_ptr;
  assign sel   = arb_gnt[REQ_SPI];
  assign o_gnt = arb_gnt;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|arb_gnt) state_next = ISSUE;
      ISSUE:   state_next = we_reg ? RESP : WAIT;
      WAIT:    if (cnt_reg == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture registers and latency counter. The PIM command fields only
  // change on a grant, so they stay put outside the ISSUE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      if (|arb_gnt) begin
        we_reg    <= i_we[sel];
        addr_reg  <= i_addr[sel];
        wdata_reg <= i_wdata[sel];
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= LAT_M1;
        // A write completes with zero read data.
        if (we_reg) rdata_reg <= '0;
      end
      if (state_reg == WAIT) begin
        if (cnt_reg == '0) begin
          rdata_reg <= i_pim_rd_data;
        end else begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  end

  // Output decode
  always_comb begin
    o_pim_req = (state_reg == ISSUE);
    o_busy    = !idle;
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rvalid
    assign o_rvalid[gi] = (state_reg == RESP) && (owner == 1'(gi));
  end

  assign o_pim_we      = we_reg;
  assign o_pim_addr    = addr_reg;
  assign o_pim_wr_data = wdata_reg;
  assign o_rdata       = rdata_reg;

endmodule
